db_sao_bo_ctrl: RTL
===================

DB_SAO_BO_CTRL -- requirements
Module: db_sao_bo_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start_i, input, 1, one-cycle pulse starting statistics for one CTB component.
REQ-004 SHALL have port pix_num_i, input, 13, pixel count for the CTB component (1..4096); sampled when start_i is accepted.
REQ-005 SHALL have port pix_valid_i, input, 1, qualifies dp_i/op_i this cycle.
REQ-006 SHALL have port dp_i, input, 8, deblocked pixel.
REQ-007 SHALL have port op_i, input, 8, original pixel.
REQ-008 SHALL have port rd_band_i, input, 5, band index for the statistics read port.
REQ-009 SHALL have port busy_o, output, 1, high from start acceptance until done_o inclusive.
REQ-010 SHALL have port done_o, output, 1, one-cycle pulse when band_pos_o/band_cost_o are final.
REQ-011 SHALL have port band_pos_o, output, 5, selected SAO band position (first of 4 consecutive bands).
REQ-012 SHALL have port band_cost_o, output, 22, unsigned metric of the selected window.
REQ-013 SHALL have port rd_sum_o, output, 21, signed diff sum of band rd_band_i (combinational read).
REQ-014 SHALL have port rd_cnt_o, output, 13, pixel count of band rd_band_i (combinational read).

Function
REQ-015 SHALL implement FSM states IDLE, ACC, SCAN, DONE; reset state IDLE.
REQ-016 SHALL in IDLE accept start_i: latch pix_num_i, clear all 32 sums/counts, clear pixel counter, go to ACC next cycle.
REQ-017 SHALL ignore start_i in ACC, SCAN, DONE.
REQ-018 SHALL treat pix_num_i = 0 as "no pixels": ACC exits to SCAN after one cycle with all-zero statistics.
REQ-019 SHALL in ACC, per cycle with pix_valid_i=1, compute band = dp_i[7:3] and diff = op_i - dp_i as 9-bit signed (range -255..255).
REQ-020 SHALL add sign-extended diff to sum[band] (21-bit signed, no saturation needed: max |sum| 1,044,480) and increment cnt[band] (13-bit).
REQ-021 SHALL ignore pix_valid_i outside ACC and leave statistics unchanged.
REQ-022 SHALL increment the pixel counter per accepted pixel; when the accepted pixel is number pix_num_i, go to SCAN next cycle; further pixels not accepted.
REQ-023 SHALL in SCAN evaluate one window b = 0..28 per cycle (29 cycles): cost(b) = |sum[b]|+|sum[b+1]|+|sum[b+2]|+|sum[b+3]| (22-bit unsigned).
REQ-024 SHALL keep best = max cost; on ties keep the lower b; window b=0 always initialises best.
REQ-025 SHALL after b=28 enter DONE for exactly one cycle, pulse done_o, update band_pos_o/band_cost_o, then return to IDLE.
REQ-026 SHALL hold band_pos_o/band_cost_o and statistics stable after done_o until the next accepted start_i.
REQ-027 SHALL meet latency: last pixel accepted in cycle N -> done_o in cycle N+30.
REQ-028 SHALL provide rd_sum_o/rd_cnt_o valid in all states (intermediate values during ACC).

Reset
REQ-029 SHALL on rst_n low, asynchronously: state IDLE, busy_o=0, done_o=0, band_pos_o=0, band_cost_o=0, all sums/counts/counters 0.
REQ-030 SHALL on rst_n assertion mid-ACC/SCAN abandon the operation; no done_o after release until a new start_i.

Verification
REQ-031 SHALL cover: start, pix_num_i=4, pixels (dp,op)=(40,50)x4 -> band 5 sum=40 cnt=4; band_pos_o=2, band_cost_o=40; done_o 30 cycles after 4th pixel.
REQ-032 SHALL cover: all-zero diffs over 64 pixels -> band_cost_o=0, band_pos_o=0 (tie rule).
REQ-033 SHALL cover: 4096 pixels dp=255, op=0 -> sum[31]=-1,044,480, cnt[31]=4096 (13-bit, no overflow), band_pos_o=28, band_cost_o=1,044,480.
REQ-034 SHALL cover: start_i pulsed during ACC and SCAN, pix_valid_i during IDLE/SCAN -> ignored, results unchanged.
REQ-035 SHALL cover: rst_n low mid-SCAN -> outputs/statistics 0 immediately, no done_o; pix_num_i=0 start -> done_o with cost 0.

Source files
------------

// File: rtl/db_sao_bo_ctrl.sv
// SAO band-offset statistics: accumulates per-band diff sums/counts for one CTB
// component, then scans the 29 four-band windows for the largest |sum| total.
module db_sao_bo_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [12:0] pix_num_i,
  input  logic        pix_valid_i,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  op_i,
  input  logic [4:0]  rd_band_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [4:0]  band_pos_o,
  output logic [21:0] band_cost_o,
  output logic [20:0] rd_sum_o,
  output logic [12:0] rd_cnt_o
);

  typedef enum logic [1:0] {IDLE, ACC, SCAN, DONE} state_t;

  localparam logic [4:0] LAST_WIN = 5'd28;

  state_t             state_q, state_d;
  logic [12:0]        pix_num_q, pix_num_d;
  logic [12:0]        pix_cnt_q, pix_cnt_d;
  logic [4:0]         scan_b_q, scan_b_d;
  logic [4:0]         best_pos_q, best_pos_d;
  logic [21:0]        best_cost_q, best_cost_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [4:0]         band_pos_q, band_pos_d;
  logic [21:0]        band_cost_q, band_cost_d;
  logic signed [20:0] sum_q [32];
  logic signed [20:0] sum_d [32];
  logic [12:0]        cnt_q [32];
  logic [12:0]        cnt_d [32];

  logic [4:0]         pix_band;
  logic signed [8:0]  pix_diff;
  logic [21:0]        win_cost;

  function automatic logic [21:0] mag(input logic signed [20:0] v);
    logic [20:0] u;
    u = $unsigned(v);
    return v[20] ? {1'b0, ~u + 21'd1} : {1'b0, u};
  endfunction

  assign pix_band = dp_i[7:3];
  assign pix_diff = $signed({1'b0, op_i}) - $signed({1'b0, dp_i});
  assign win_cost = mag(sum_q[scan_b_q]) + mag(sum_q[scan_b_q + 5'd1])
                  + mag(sum_q[scan_b_q + 5'd2]) + mag(sum_q[scan_b_q + 5'd3]);

  always_comb begin
    state_d     = state_q;
    pix_num_d   = pix_num_q;
    pix_cnt_d   = pix_cnt_q;
    scan_b_d    = scan_b_q;
    best_pos_d  = best_pos_q;
    best_cost_d = best_cost_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    band_pos_d  = band_pos_q;
    band_cost_d = band_cost_q;
    for (int i = 0; i < 32; i++) begin
      sum_d[i] = sum_q[i];
      cnt_d[i] = cnt_q[i];
    end
    case (state_q)
      IDLE: begin
        if (start_i) begin
          pix_num_d = pix_num_i;
          pix_cnt_d = 13'd0;
          busy_d    = 1'b1;
          state_d   = ACC;
          for (int i = 0; i < 32; i++) begin
            sum_d[i] = '0;
            cnt_d[i] = '0;
          end
        end
      end
      ACC: begin
        if (pix_num_q == 13'd0) begin
          scan_b_d = 5'd0;
          state_d  = SCAN;
        end else if (pix_valid_i) begin
          sum_d[pix_band] = sum_q[pix_band] + {{12{pix_diff[8]}}, pix_diff};
          cnt_d[pix_band] = cnt_q[pix_band] + 13'd1;
          pix_cnt_d       = pix_cnt_q + 13'd1;
          if (pix_cnt_d == pix_num_q) begin
            scan_b_d = 5'd0;
            state_d  = SCAN;
          end
        end
      end
      SCAN: begin
        // Strict '>' keeps the lowest window on ties; window 0 always seeds.
        if (scan_b_q == 5'd0 || win_cost > best_cost_q) begin
          best_pos_d  = scan_b_q;
          best_cost_d = win_cost;
        end
        scan_b_d = scan_b_q + 5'd1;
        if (scan_b_q == LAST_WIN) begin
          band_pos_d  = best_pos_d;
          band_cost_d = best_cost_d;
          done_d      = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pix_num_q   <= '0;
      pix_cnt_q   <= '0;
      scan_b_q    <= '0;
      best_pos_q  <= '0;
      best_cost_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      band_pos_q  <= '0;
      band_cost_q <= '0;
      for (int i = 0; i < 32; i++) begin
        sum_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pix_num_q   <= pix_num_d;
      pix_cnt_q   <= pix_cnt_d;
      scan_b_q    <= scan_b_d;
      best_pos_q  <= best_pos_d;
      best_cost_q <= best_cost_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      band_pos_q  <= band_pos_d;
      band_cost_q <= band_cost_d;
      for (int i = 0; i < 32; i++) begin
        sum_q[i] <= sum_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign band_pos_o  = band_pos_q;
  assign band_cost_o = band_cost_q;
  assign rd_sum_o    = $unsigned(sum_q[rd_band_i]);
  assign rd_cnt_o    = cnt_q[rd_band_i];

endmodule
